// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared defaults, stall-cause bit indices and width helper for
//            the decode-stage hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  localparam int REG_AW_DEF  = 5;
  localparam int CNT_W_DEF   = 3;
  localparam int MAX_VAR_DEF = 2;
  localparam int PERF_W_DEF  = 32;

  // Bit positions inside the internal stall-cause vector
  localparam int CAUSE_RAW    = 0;
  localparam int CAUSE_WAW    = 1;
  localparam int CAUSE_STRUCT = 2;
  localparam int NUM_CAUSES   = 3;

  // Ceiling log2 with a floor of 1 bit, used to size the outstanding-op counter
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_reg_entry.sv
`default_nettype none
// ============================================================================
// Module   : hazard_reg_entry
// Brief    : Tracking state for one architectural register: fixed-latency
//            countdown plus variable-latency pending bit.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_reg_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_fix,
  input  logic [CNT_W-1:0] fix_lat,
  input  logic             set_var,
  input  logic             clr_var,
  output logic [CNT_W-1:0] cnt,
  output logic             pend,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d, w_cnt_dec;
  logic             pend_q, pend_d;

  // Countdown saturates at zero; a new fixed write keeps the later of the two ready times
  always_comb begin
    w_cnt_dec = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;
    cnt_d     = w_cnt_dec;
    if (set_fix && (fix_lat > w_cnt_dec)) cnt_d = fix_lat;
    pend_d = pend_q;
    if (clr_var)      pend_d = 1'b0;
    else if (set_var) pend_d = 1'b1;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign cnt  = cnt_q;
  assign pend = pend_q;
  assign busy = (cnt_q != '0) || pend_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Decode-stage per-register scoreboard. Stalls IF/ID on RAW, WAW
//            across tracking classes and variable-unit capacity, counts stall
//            cycles and flags writebacks to untracked registers.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_VAR = MAX_VAR_DEF,
  parameter int PERF_W  = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_var,
  input  logic [CNT_W-1:0]  id_lat,
  input  logic              flush,
  input  logic              var_wb_valid,
  input  logic [REG_AW-1:0] var_wb_rd,
  output logic              stall,
  output logic              stall_raw,
  output logic              stall_waw,
  output logic              stall_struct,
  output logic              var_busy,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              sb_err
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int VAR_W    = clog2(MAX_VAR + 1);

  logic [CNT_W-1:0]      w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0]   w_pend;
  logic [NUM_REGS-1:0]   w_busy;
  logic [NUM_CAUSES-1:0] w_cause;
  logic                  w_stall, w_issue, w_wb_hit;

  logic [VAR_W-1:0]  var_out_q, var_out_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic              sb_err_q, sb_err_d;

  // x0 is hardwired and never tracked
  assign w_cnt[0]  = '0;
  assign w_pend[0] = 1'b0;
  assign w_busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_reg_entry #(
      .CNT_W   (CNT_W)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_fix (w_issue && !id_var && (id_rd == REG_AW'(r))),
      .fix_lat (id_lat),
      .set_var (w_issue && id_var && (id_rd == REG_AW'(r))),
      .clr_var (w_wb_hit && (var_wb_rd == REG_AW'(r))),
      .cnt     (w_cnt[r]),
      .pend    (w_pend[r]),
      .busy    (w_busy[r])
    );
  end

  // Stall causes from registered tracking state only; writeback is not bypassed
  always_comb begin
    w_cause = '0;
    w_cause[CAUSE_RAW] = id_valid &&
                         ((id_rs1_used && w_busy[id_rs1]) || (id_rs2_used && w_busy[id_rs2]));
    w_cause[CAUSE_WAW] = id_valid && id_rd_we && (id_rd != '0) &&
                         (id_var ? ((w_cnt[id_rd] != '0) || w_pend[id_rd]) : w_pend[id_rd]);
    w_cause[CAUSE_STRUCT] = id_valid && id_rd_we && id_var && (var_out_q == VAR_W'(MAX_VAR));
    w_stall  = |w_cause;
    w_issue  = id_valid && !w_stall && !flush && id_rd_we && (id_rd != '0);
    w_wb_hit = var_wb_valid && w_pend[var_wb_rd];
  end

  // Outstanding variable-op count, stall counter and sticky writeback error
  always_comb begin
    var_out_d = var_out_q;
    if (w_issue && id_var) var_out_d = var_out_d + VAR_W'(1);
    if (w_wb_hit)          var_out_d = var_out_d - VAR_W'(1);
    stall_cycles_d = stall_cycles_q;
    if (w_stall) stall_cycles_d = stall_cycles_q + PERF_W'(1);
    sb_err_d = sb_err_q || (var_wb_valid && !w_wb_hit);
  end

  // Top-level registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_out_q      <= '0;
      stall_cycles_q <= '0;
      sb_err_q       <= 1'b0;
    end else begin
      var_out_q      <= var_out_d;
      stall_cycles_q <= stall_cycles_d;
      sb_err_q       <= sb_err_d;
    end
  end

  assign stall        = w_stall;
  assign stall_raw    = w_cause[CAUSE_RAW];
  assign stall_waw    = w_cause[CAUSE_WAW];
  assign stall_struct = w_cause[CAUSE_STRUCT];
  assign var_busy     = (var_out_q != '0);
  assign stall_cycles = stall_cycles_q;
  assign sb_err       = sb_err_q;

endmodule
`default_nettype wire
